// File: rtl/instr_loader_pkg.sv
// ----------------------------------------------------------------------------
// instr_loader_pkg
// Shared types and constants for the instruction loader front-end.
//   state_t   : loader FSM encoding (COLLECT / PENDING)
//   NIBBLES   : switch presses per instruction
//   NIB_W     : width of one switch nibble
//   OPCODE_W  : opcode field width
//   INSTR_W   : instruction body width
//   INST_W    : full staged instruction width (opcode + body)
//   IDX_W     : width of the nibble index
// ----------------------------------------------------------------------------
package instr_loader_pkg;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    localparam int NIBBLES  = 4;
    localparam int NIB_W    = 4;
    localparam int OPCODE_W = 4;
    localparam int INSTR_W  = 12;
    localparam int INST_W   = OPCODE_W + INSTR_W;
    localparam int IDX_W    = 2;

endpackage

// File: rtl/instr_loader_if.sv
// ----------------------------------------------------------------------------
// instr_loader_if
// Bundles the front-panel inputs and the core-facing outputs of the loader.
//   btn_raw   : raw push button (asynchronous)
//   nib_in    : switch nibble
//   entry_clr : discard partial entry
//   core_busy : core executing, hold off issue
//   opcode    : issued opcode
//   instr     : issued instruction body
//   inst_done : one-cycle issue strobe
//   btn_edge  : one-cycle debounced press pulse
//   nib_idx   : next nibble to be entered
//   pending   : full instruction staged
//   overrun   : sticky dropped-press flag
// Modports: slave = loader side, master = driving/observing side.
// ----------------------------------------------------------------------------
interface instr_loader_if;
    import instr_loader_pkg::*;

    logic                btn_raw;
    logic [NIB_W-1:0]    nib_in;
    logic                entry_clr;
    logic                core_busy;
    logic [OPCODE_W-1:0] opcode;
    logic [INSTR_W-1:0]  instr;
    logic                inst_done;
    logic                btn_edge;
    logic [IDX_W-1:0]    nib_idx;
    logic                pending;
    logic                overrun;

    modport slave (
        input  btn_raw, nib_in, entry_clr, core_busy,
        output opcode, instr, inst_done, btn_edge, nib_idx, pending, overrun
    );

    modport master (
        output btn_raw, nib_in, entry_clr, core_busy,
        input  opcode, instr, inst_done, btn_edge, nib_idx, pending, overrun
    );

endinterface

// File: rtl/instr_loader_btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
// Synchronizes an asynchronous push button, debounces it and emits a
// registered one-cycle pulse on each accepted 0->1 transition.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   i_btn_raw : raw button level
//   o_rise    : one-cycle pulse per debounced rising press
// Pulse appears in the cycle after edge N+SYNC_STAGES+DEBOUNCE-1, where N is
// the first edge sampling the button high.
// ----------------------------------------------------------------------------
module btn_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_raw,
    output logic o_rise
);

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_db;
    logic                   r_rise;
    logic                   w_s;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign o_rise = r_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_db   <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn_raw};
            r_rise <= 1'b0;
            if (w_s == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_TC) begin
                // Level held long enough: accept it; pulse only on a press.
                r_db   <= w_s;
                r_cnt  <= '0;
                r_rise <= w_s;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/instr_loader.sv
// ----------------------------------------------------------------------------
// instr_loader
// Collects a 16-bit instruction from four debounced presses of a 4-bit switch
// bus (opcode first, then instr[11:8], [7:4], [3:0]) into a shadow buffer,
// then issues it to the bit-serial core once the core is not busy. The issued
// opcode/instr are held, so the core sees a stable instruction while the next
// one is being entered.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : instr_loader_if.slave (front-panel inputs, core-facing outputs)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// COLLECT  | accepting nibbles; entry_clr clears the partial entry
// PENDING  | full instruction staged, waiting for core_busy low to issue
// ----------------------------------------------------------------------------
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 3
) (
    input  logic           clk,
    input  logic           rst,
    instr_loader_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t              r_state;
    logic [INST_W-1:0]   r_shadow;
    logic [IDX_W-1:0]    r_nib_idx;
    logic                r_pending;
    logic                r_overrun;
    logic                r_inst_done;
    logic [OPCODE_W-1:0] r_opcode;
    logic [INSTR_W-1:0]  r_instr;

    state_t              w_state_nxt;
    logic [INST_W-1:0]   w_shadow_nxt;
    logic [IDX_W-1:0]    w_nib_idx_nxt;
    logic                w_pending_nxt;
    logic                w_overrun_nxt;
    logic                w_issue;
    logic                w_btn_edge;

    btn_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE    (DEBOUNCE),
        .CNT_W       (CNT_W)
    ) u_btn_debounce (
        .clk       (clk),
        .rst       (rst),
        .i_btn_raw (bus.btn_raw),
        .o_rise    (w_btn_edge)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_shadow_nxt  = r_shadow;
        w_nib_idx_nxt = r_nib_idx;
        w_pending_nxt = r_pending;
        w_overrun_nxt = r_overrun;
        w_issue       = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                // entry_clr has priority: a press in the same cycle is dropped.
                if (bus.entry_clr) begin
                    w_nib_idx_nxt = '0;
                    w_shadow_nxt  = '0;
                end else if (w_btn_edge) begin
                    case (r_nib_idx)
                        2'd0:    w_shadow_nxt[15:12] = bus.nib_in;
                        2'd1:    w_shadow_nxt[11:8]  = bus.nib_in;
                        2'd2:    w_shadow_nxt[7:4]   = bus.nib_in;
                        default: w_shadow_nxt[3:0]   = bus.nib_in;
                    endcase
                    if (r_nib_idx == LAST_IDX) begin
                        w_nib_idx_nxt = '0;
                        w_pending_nxt = 1'b1;
                        w_state_nxt   = ST_PENDING;
                    end else begin
                        w_nib_idx_nxt = r_nib_idx + IDX_W'(1);
                    end
                end
            end
            ST_PENDING: begin
                // Shadow is frozen here; a press is only recorded as lost.
                if (w_btn_edge) begin
                    w_overrun_nxt = 1'b1;
                end
                if (!bus.core_busy) begin
                    w_issue       = 1'b1;
                    w_pending_nxt = 1'b0;
                    w_state_nxt   = ST_COLLECT;
                end
            end
            default: begin
                w_state_nxt = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_COLLECT;
            r_shadow    <= '0;
            r_nib_idx   <= '0;
            r_pending   <= 1'b0;
            r_overrun   <= 1'b0;
            r_inst_done <= 1'b0;
            r_opcode    <= '0;
            r_instr     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_shadow    <= w_shadow_nxt;
            r_nib_idx   <= w_nib_idx_nxt;
            r_pending   <= w_pending_nxt;
            r_overrun   <= w_overrun_nxt;
            r_inst_done <= w_issue;
            if (w_issue) begin
                r_opcode <= r_shadow[INST_W-1:INSTR_W];
                r_instr  <= r_shadow[INSTR_W-1:0];
            end
        end
    end

    assign bus.opcode    = r_opcode;
    assign bus.instr     = r_instr;
    assign bus.inst_done = r_inst_done;
    assign bus.btn_edge  = w_btn_edge;
    assign bus.nib_idx   = r_nib_idx;
    assign bus.pending   = r_pending;
    assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_instr_loader.sv
// ----------------------------------------------------------------------------
// tb_instr_loader
// Directed bench for instr_loader (SYNC_STAGES=2, DEBOUNCE=4). Expected
// issued instructions are queued as stimulus is applied; a negedge monitor
// pops and compares on every inst_done.
// ----------------------------------------------------------------------------
module tb_instr_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_vec  = 0;
    int n_err  = 0;
    int n_done = 0;
    int n_edges = 0;
    logic prev_done = 1'b0;
    logic [15:0] exp_q[$];

    instr_loader_if u_if ();

    instr_loader #(
        .SYNC_STAGES (2),
        .DEBOUNCE    (4),
        .CNT_W       (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (u_if.btn_edge) n_edges++;
            if (u_if.inst_done) begin
                n_done++;
                n_vec++;
                if (prev_done) begin
                    n_err++;
                    $display("FAIL inst_done_back_to_back: got two consecutive pulses, required isolated pulse");
                end
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_issue: got opcode=%h instr=%h, required no inst_done",
                             u_if.opcode, u_if.instr);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if ({u_if.opcode, u_if.instr} !== e) begin
                        n_err++;
                        $display("FAIL issue_data: got %h_%h, required %h_%h",
                                 u_if.opcode, u_if.instr, e[15:12], e[11:0]);
                    end
                end
            end
            prev_done = u_if.inst_done;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] n);
        u_if.nib_in  = n;
        u_if.btn_raw = 1'b1;
        repeat (8) @(posedge clk);
        #1 u_if.btn_raw = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_opcode"},    32'(u_if.opcode),    32'h0);
        check({tag, "_instr"},     32'(u_if.instr),     32'h0);
        check({tag, "_inst_done"}, 32'(u_if.inst_done), 32'h0);
        check({tag, "_btn_edge"},  32'(u_if.btn_edge),  32'h0);
        check({tag, "_nib_idx"},   32'(u_if.nib_idx),   32'h0);
        check({tag, "_pending"},   32'(u_if.pending),   32'h0);
        check({tag, "_overrun"},   32'(u_if.overrun),   32'h0);
    endtask

    initial begin
        int e0;
        int d0;
        u_if.btn_raw   = 1'b0;
        u_if.nib_in    = 4'h0;
        u_if.entry_clr = 1'b0;
        u_if.core_busy = 1'b0;

        // Reset state
        do_reset();
        check_zero_outputs("reset");

        // Latency: btn_edge only in the cycle after edge N+5
        @(posedge clk);
        #1 u_if.btn_raw = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("latency_edge_N+%0d", k), 32'(u_if.btn_edge), (k == 5) ? 32'h1 : 32'h0);
        end
        check("latency_nib_idx", 32'(u_if.nib_idx), 32'h1);
        @(posedge clk);
        #1 u_if.btn_raw = 1'b0;
        repeat (10) @(posedge clk);
        #1 u_if.entry_clr = 1'b1;
        @(posedge clk);
        #1 u_if.entry_clr = 1'b0;
        check("entry_clr_nib_idx", 32'(u_if.nib_idx), 32'h0);

        // Glitch shorter than the debounce window
        e0 = n_edges;
        u_if.btn_raw = 1'b1;
        repeat (2) @(posedge clk);
        #1 u_if.btn_raw = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("glitch_no_edge", 32'(n_edges - e0), 32'h0);
        check("glitch_nib_idx", 32'(u_if.nib_idx), 32'h0);

        // Full entry, core idle
        e0 = n_edges;
        d0 = n_done;
        exp_q.push_back(16'hA3C5);
        press(4'hA);
        check("full_nib_idx_1", 32'(u_if.nib_idx), 32'h1);
        press(4'h3);
        press(4'hC);
        press(4'h5);
        check("full_edges", 32'(n_edges - e0), 32'h4);
        check("full_issued", 32'(n_done - d0), 32'h1);
        check("full_nib_idx", 32'(u_if.nib_idx), 32'h0);
        check("full_pending", 32'(u_if.pending), 32'h0);
        check("full_opcode_held", 32'(u_if.opcode), 32'hA);
        check("full_instr_held", 32'(u_if.instr), 32'h3C5);

        // Back-pressure, overrun, then release
        u_if.core_busy = 1'b1;
        d0 = n_done;
        press(4'hA);
        press(4'h3);
        press(4'hC);
        press(4'h5);
        check("bp_pending", 32'(u_if.pending), 32'h1);
        check("bp_no_issue", 32'(n_done - d0), 32'h0);
        check("bp_overrun_before", 32'(u_if.overrun), 32'h0);
        press(4'hF);
        check("bp_overrun", 32'(u_if.overrun), 32'h1);
        check("bp_still_pending", 32'(u_if.pending), 32'h1);
        exp_q.push_back(16'hA3C5);
        u_if.core_busy = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bp_issued", 32'(n_done - d0), 32'h1);
        check("bp_pending_clear", 32'(u_if.pending), 32'h0);
        check("bp_overrun_sticky", 32'(u_if.overrun), 32'h1);

        // Abort partial entry, then a fresh instruction
        press(4'h1);
        press(4'h2);
        check("abort_nib_idx_pre", 32'(u_if.nib_idx), 32'h2);
        u_if.entry_clr = 1'b1;
        @(posedge clk);
        #1 u_if.entry_clr = 1'b0;
        check("abort_nib_idx", 32'(u_if.nib_idx), 32'h0);
        exp_q.push_back(16'h7009);
        press(4'h7);
        press(4'h0);
        press(4'h0);
        press(4'h9);
        check("abort_opcode", 32'(u_if.opcode), 32'h7);
        check("abort_instr", 32'(u_if.instr), 32'h009);

        // Simultaneous btn_edge and entry_clr: nibble dropped
        press(4'h4);
        check("simul_nib_idx_pre", 32'(u_if.nib_idx), 32'h1);
        u_if.nib_in  = 4'hE;
        u_if.btn_raw = 1'b1;
        repeat (6) @(posedge clk);
        #1 u_if.entry_clr = 1'b1;
        @(negedge clk);
        check("simul_btn_edge", 32'(u_if.btn_edge), 32'h1);
        @(posedge clk);
        #1 u_if.entry_clr = 1'b0;
        check("simul_nib_idx", 32'(u_if.nib_idx), 32'h0);
        u_if.btn_raw = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("simul_nib_idx_after", 32'(u_if.nib_idx), 32'h0);

        // Reset while pending: nothing issued afterwards
        u_if.core_busy = 1'b1;
        press(4'hB);
        press(4'h1);
        press(4'h2);
        press(4'h3);
        check("rstpend_pending", 32'(u_if.pending), 32'h1);
        d0 = n_done;
        do_reset();
        check_zero_outputs("rstpend");
        u_if.core_busy = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("rstpend_no_issue", 32'(n_done - d0), 32'h0);
        check("rstpend_opcode", 32'(u_if.opcode), 32'h0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
